// File: rtl/float_pkg.sv
// float_pkg: binary32 field widths and constants, FSM states and the unpacked-operand type shared by float_mul.
package float_pkg;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int SIG_W = MANT_W + 1;
  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  typedef struct packed {
    logic             sign;
    logic [9:0]       exp;
    logic [SIG_W-1:0] mant;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } ufloat_t;
endpackage

// File: rtl/float_unpack.sv
// float_unpack: splits one binary32 operand into sign/exponent/significand and classifies it.
// FLOAT_MUL_DENORM_EN keeps subnormals (hidden bit 0, exponent 1); otherwise they read as signed zero.
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0] v,
  output ufloat_t     u
);
  logic [EXP_W-1:0]  e;
  logic [MANT_W-1:0] f;
  assign e = v[30:23];
  assign f = v[22:0];
  always_comb begin
    u.sign   = v[31];
    u.is_nan = (e == EXP_W'(EXP_MAX)) && |f;
    u.is_inf = (e == EXP_W'(EXP_MAX)) && ~|f;
`ifdef FLOAT_MUL_DENORM_EN
    u.is_zero = ~|e && ~|f;
    u.mant    = {|e, f};
    u.exp     = ~|e ? 10'd1 : {2'b0, e};
`else
    u.is_zero = ~|e;
    u.mant    = {1'b1, f};
    u.exp     = {2'b0, e};
`endif
  end
endmodule

// File: rtl/float_mul.sv
// float_mul: sequential binary32 multiplier, 24-step shift-add significand product, RNE rounding.
// FLOAT_MUL_DENORM_EN enables gradual underflow; default build flushes subnormals to signed zero.
module float_mul
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] vres,
  output logic        out_valid,
  input  logic        out_ready
);
  state_t            state, nxt;
  ufloat_t           ua, ub;
  logic              hs, rdy, sgn, fnan, finf, fzero, rnd, ovf, uf;
  logic [4:0]        cnt;
  logic [47:0]       prod;
  logic [SIG_W-1:0]  ma;
  logic [24:0]       acc;
  logic signed [9:0] e, en;
  logic [5:0]        lz;
  logic [46:0]       y;
  logic [30:0]       pk;
  logic [31:0]       res;
`ifdef FLOAT_MUL_DENORM_EN
  logic [9:0]        r;
`endif

  float_unpack u_a (.v(v1), .u(ua));
  float_unpack u_b (.v(v2), .u(ub));

  assign hs = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb
    nxt = state == IDLE ? (hs ? MUL : IDLE) :
          state == MUL  ? (cnt == 5'd23 ? NORM : MUL) :
          state == NORM ? DONE :
          (out_ready ? IDLE : DONE);

  always_comb begin
    in_ready  = rdy & (state == IDLE);
    out_valid = state == DONE;
  end

  // Right-shifting accumulator: {acc, multiplier} shifts down one bit per step.
  assign acc = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, ma} : 25'd0);

  always_comb begin
    lz = 6'd48;
    for (int i = 0; i < 48; i++) if (prod[i]) lz = 6'(47 - i);
    en = e + 10'sd1 - $signed({4'b0, lz});
    y  = 47'(prod << lz);
`ifdef FLOAT_MUL_DENORM_EN
    r  = -e;
    // Subnormal result: align to exponent 1, folding shifted-out bits into sticky.
    if (en < 10'sd1)
      y = ~e[9] ? 47'(prod << e[5:0]) :
          r > 10'd47 ? {46'b0, |prod} :
          47'(prod >> r) | {46'b0, |(prod & ~({48{1'b1}} << r))};
    uf = 1'b0;
`else
    uf = en < 10'sd1;
`endif
    rnd = y[23] & (|y[22:0] | y[24]);
    pk  = {en > 10'sd0 ? en[7:0] : 8'd0, y[46:24]} + 31'(rnd);
    ovf = (en >= 10'sd255) | &pk[30:23];
    res = fnan ? QNAN :
          finf ? (POS_INF | {sgn, 31'b0}) :
          (fzero | uf) ? {sgn, 31'b0} :
          ovf ? (POS_INF | {sgn, 31'b0}) :
          {sgn, pk};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy   <= 1'b0;
      cnt   <= 5'd0;
      prod  <= 48'd0;
      ma    <= '0;
      sgn   <= 1'b0;
      e     <= 10'sd0;
      fnan  <= 1'b0;
      finf  <= 1'b0;
      fzero <= 1'b0;
      vres  <= 32'd0;
    end else begin
      rdy <= 1'b1;
      if (hs) begin
        cnt   <= 5'd0;
        prod  <= {24'd0, ub.mant};
        ma    <= ua.mant;
        sgn   <= ua.sign ^ ub.sign;
        e     <= $signed(ua.exp + ub.exp - 10'(BIAS));
        fnan  <= ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_zero) | (ua.is_zero & ub.is_inf);
        finf  <= ua.is_inf | ub.is_inf;
        fzero <= ua.is_zero | ub.is_zero;
      end
      if (state == MUL) begin
        prod <= {acc, prod[23:1]};
        cnt  <= cnt == 5'd23 ? 5'd0 : cnt + 5'd1;
      end
      if (state == NORM) vres <= res;
    end
endmodule
